// File: rtl/moore_step_checker_if.sv
// DUT-facing side of the Moore step checker: reset/step/switch drive and state/output sense.
interface moore_step_checker_if #(
    parameter int unsigned SW_W    = 2,
    parameter int unsigned STATE_W = 3
);
    logic               dut_reset;
    logic               dut_ctrl;
    logic [SW_W-1:0]    dut_sw;
    logic [STATE_W-1:0] dut_state_in;
    logic [STATE_W-1:0] dut_state;
    logic               dut_out;

    modport master (
        output dut_reset,
        output dut_ctrl,
        output dut_sw,
        output dut_state_in,
        input  dut_state,
        input  dut_out
    );

    modport slave (
        input  dut_reset,
        input  dut_ctrl,
        input  dut_sw,
        input  dut_state_in,
        output dut_state,
        output dut_out
    );
endinterface

// File: rtl/moore_step_checker.sv
// Table-driven lockstep checker for Moore machines with a step enable.
// Optional MOORE_CHK_STOP_ON_ERR_EN: end the run at the first mismatching step.
module moore_step_checker #(
    parameter int unsigned NUM_STATES = 2,
    parameter int unsigned SW_W       = 2,
    parameter int unsigned STATE_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [STATE_W+SW_W-1:0]   cfg_addr,
    input  logic [STATE_W:0]          cfg_data,
    input  logic [STATE_W-1:0]        cfg_init,
    input  logic                      start,
    input  logic                      vec_valid,
    input  logic [SW_W-1:0]           vec_sw,
    input  logic                      vec_last,
    output logic                      vec_ready,
    moore_step_checker_if.master      dut,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                err_cnt,
    output logic [15:0]               first_err_step,
    output logic                      illegal,
    output logic [15:0]               step_cnt
);
    localparam int unsigned AddrW = STATE_W + SW_W;
    localparam int unsigned Depth = 1 << AddrW;

    typedef enum logic [2:0] {
        StIdle, StRst, StFetch, StDrive, StStep, StCheck, StDone
    } state_e;

    state_e state_q, state_d;

    logic [STATE_W:0]   table_q [Depth];
    logic [STATE_W:0]   entry;

    logic [STATE_W-1:0] model_q, model_d;
    logic [SW_W-1:0]    sw_q, sw_d;
    logic               last_q, last_d;
    logic               exp_out_q, exp_out_d;
    logic [STATE_W-1:0] exp_next_q, exp_next_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [15:0]        first_err_q, first_err_d;
    logic               illegal_q, illegal_d;
    logic [15:0]        step_cnt_q, step_cnt_d;

    logic               dut_illegal;
    logic               mismatch;

    // Table has no reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == StIdle)) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    // Out-of-range model states are indexed as-is; only the DUT side raises illegal.
    assign entry       = table_q[{model_q, sw_q}];
    assign dut_illegal = 32'(dut.dut_state) >= NUM_STATES;
    assign mismatch    = dut_illegal || (dut.dut_state != exp_next_q) ||
                         (dut.dut_out != exp_out_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRst;
            StRst:   state_d = StFetch;
            StFetch: if (vec_valid) state_d = StDrive;
            StDrive: state_d = StStep;
            StStep:  state_d = StCheck;
            StCheck: begin
`ifdef MOORE_CHK_STOP_ON_ERR_EN
                state_d = (last_q || mismatch) ? StDone : StFetch;
`else
                state_d = last_q ? StDone : StFetch;
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vec_ready        = (state_q == StFetch);
        busy             = (state_q != StIdle);
        done             = (state_q == StDone);
        dut.dut_reset    = (state_q == StRst);
        dut.dut_ctrl     = (state_q == StStep);
        dut.dut_sw       = sw_q;
        dut.dut_state_in = cfg_init;
        err_cnt          = err_cnt_q;
        first_err_step   = first_err_q;
        illegal          = illegal_q;
        step_cnt         = step_cnt_q;
    end

    always_comb begin
        model_d     = model_q;
        sw_d        = sw_q;
        last_d      = last_q;
        exp_out_d   = exp_out_q;
        exp_next_d  = exp_next_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        illegal_d   = illegal_q;
        step_cnt_d  = step_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    illegal_d   = 1'b0;
                    step_cnt_d  = '0;
                end
            end
            StRst: model_d = '0;
            StFetch: begin
                if (vec_valid) begin
                    sw_d   = vec_sw;
                    last_d = vec_last;
                end
            end
            StStep: begin
                exp_out_d  = entry[STATE_W];
                exp_next_d = entry[STATE_W-1:0];
                model_d    = entry[STATE_W-1:0];
            end
            StCheck: begin
                if (dut_illegal) illegal_d = 1'b1;
                if (mismatch) begin
                    // err_cnt was cleared at start, so zero marks the first failure.
                    if (err_cnt_q == 8'd0) first_err_d = step_cnt_q;
                    if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
                end
                if (step_cnt_q != 16'hffff) step_cnt_d = step_cnt_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            model_q     <= '0;
            sw_q        <= '0;
            last_q      <= 1'b0;
            exp_out_q   <= 1'b0;
            exp_next_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            illegal_q   <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            model_q     <= model_d;
            sw_q        <= sw_d;
            last_q      <= last_d;
            exp_out_q   <= exp_out_d;
            exp_next_q  <= exp_next_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            illegal_q   <= illegal_d;
            step_cnt_q  <= step_cnt_d;
        end
    end
endmodule

// File: tb/tb_moore_step_checker.sv
// Directed bench: a two-state Moore DUT model with fault injection driven by the checker.
module tb_moore_step_checker;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic [2:0]  cfg_init;
    logic        start;
    logic        vec_valid;
    logic [1:0]  vec_sw;
    logic        vec_last;
    logic        vec_ready;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;
    logic [15:0] first_err_step;
    logic        illegal;
    logic [15:0] step_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ctrl_cnt = 0;
    int done_cnt = 0;

    moore_step_checker_if #(.SW_W(2), .STATE_W(3)) dif ();

    moore_step_checker #(.NUM_STATES(2), .SW_W(2), .STATE_W(3)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_init       (cfg_init),
        .start          (start),
        .vec_valid      (vec_valid),
        .vec_sw         (vec_sw),
        .vec_last       (vec_last),
        .vec_ready      (vec_ready),
        .dut            (dif),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_step (first_err_step),
        .illegal        (illegal),
        .step_cnt       (step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dif.dut_ctrl) ctrl_cnt <= ctrl_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // Reference machine: state 0 stays on sw 0, state 1 returns to 0 on odd sw; out = (state == 0).
    function automatic logic [3:0] ref_entry(input logic [2:0] s, input logic [1:0] sw);
        if (s == 3'd0) return (sw == 2'd0) ? 4'b1000 : 4'b0001;
        return sw[0] ? 4'b1000 : 4'b0001;
    endfunction

    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic [1:0] sw);
        if (s == 3'd0) return (sw == 2'd0) ? 3'd0 : 3'd1;
        return sw[0] ? 3'd0 : 3'd1;
    endfunction

    logic [2:0] m_state = 3'd0;
    int         m_steps = 0;
    int         fault_step = -1;
    logic [2:0] fault_val = 3'd0;

    always @(posedge clk) begin
        if (reset || dif.dut_reset) begin
            m_state <= dif.dut_state_in;
            m_steps <= 0;
        end else if (dif.dut_ctrl) begin
            if (m_steps == fault_step) m_state <= fault_val;
            else m_state <= ref_next(m_state, dif.dut_sw);
            m_steps <= m_steps + 1;
        end
    end

    assign dif.dut_state = m_state;
    assign dif.dut_out   = (m_state == 3'd0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_entry(input logic [4:0] addr, input logic [3:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Runs n vectors (sws packed 2 bits each, vector 0 in the LSBs) and returns start-to-done cycles.
    task automatic run_vectors(input int n, input logic [7:0] sws, input bit with_cfg,
                               input bit poke, output int lat);
        int  start_cyc;
        int  wait_cyc;
        bit  got_done;
        start = 1'b1;
        if (with_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = 5'd0;
            cfg_data = 4'b1000;
        end
        start_cyc = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        check_eq("dut_reset_pulse", 32'(dif.dut_reset), 1);
        got_done = 1'b0;
        lat = -1;
        for (int i = 0; i < n && !got_done; i++) begin
            vec_valid = 1'b1;
            vec_sw    = sws[2*i +: 2];
            vec_last  = (i == n - 1);
            if (poke && i == 1) begin
                // Corrupt entry {1,1} and re-start while busy; both must be ignored.
                cfg_we   = 1'b1;
                cfg_addr = 5'b00101;
                cfg_data = 4'b0001;
                start    = 1'b1;
                @(negedge clk);
                cfg_we   = 1'b0;
                start    = 1'b0;
            end
            wait_cyc = 0;
            while (!vec_ready && !done && wait_cyc < 50) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (i == 0) check_eq("vec_ready_latency", wait_cyc, 1);
            if (done) begin
                got_done = 1'b1;
                lat = cyc - start_cyc;
            end else if (!vec_ready) begin
                check_eq("vec_ready_timeout", 0, 1);
                got_done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        vec_valid = 1'b0;
        vec_last  = 1'b0;
        if (lat < 0) begin
            wait_cyc = 0;
            while (!done && wait_cyc < 50) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (done) lat = cyc - start_cyc;
            else check_eq("done_timeout", 0, 1);
        end
        @(negedge clk);
        check_eq("done_one_cycle", 32'({done, busy}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;
        int ctrl_before;
        int done_before;
        bit bp_ok;

        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_init = 3'd0;
        start = 1'b0; vec_valid = 1'b0; vec_sw = '0; vec_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("rst_busy_done_ready", 32'({busy, done, vec_ready}), 0);
        check_eq("rst_dut_drive", 32'({dif.dut_reset, dif.dut_ctrl, dif.dut_sw}), 0);
        check_eq("rst_err_cnt", 32'(err_cnt), 0);
        check_eq("rst_step_cnt", 32'(step_cnt), 0);
        check_eq("rst_first_illegal", 32'({first_err_step, illegal}), 0);

        cfg_init = 3'd6;
        @(negedge clk);
        check_eq("state_in_follow", 32'(dif.dut_state_in), 6);
        cfg_init = 3'd0;

        // Entry 0 starts bad; the run's start-cycle write must replace it.
        for (int s = 0; s < 2; s++) begin
            for (int sw = 0; sw < 4; sw++) begin
                if (s == 0 && sw == 0) write_entry(5'd0, 4'b0011);
                else write_entry({3'(s), 2'(sw)}, ref_entry(3'(s), 2'(sw)));
            end
        end

        // Clean run 0,1,2,3 with table write coinciding with start.
        run_vectors(4, 8'b11_10_01_00, 1'b1, 1'b0, lat);
        check_eq("clean_latency", lat, 17);
        check_eq("clean_err_cnt", 32'(err_cnt), 0);
        check_eq("clean_step_cnt", 32'(step_cnt), 4);
        check_eq("clean_illegal", 32'(illegal), 0);

        // DUT forced to state 0 on its second step.
        fault_step = 1; fault_val = 3'd0;
        run_vectors(4, 8'b11_10_01_00, 1'b0, 1'b0, lat);
        fault_step = -1;
        check_eq("fault_err_cnt", 32'(err_cnt), 1);
        check_eq("fault_first_err", 32'(first_err_step), 1);
        check_eq("fault_step_cnt", 32'(step_cnt), 4);

        // One-vector run where the DUT lands in state 5.
        fault_step = 0; fault_val = 3'd5;
        run_vectors(1, 8'b00_00_00_01, 1'b0, 1'b0, lat);
        fault_step = -1;
        check_eq("illegal_latency", lat, 5);
        check_eq("illegal_flag", 32'(illegal), 1);
        check_eq("illegal_err_cnt", 32'(err_cnt), 1);
        check_eq("illegal_step_cnt", 32'(step_cnt), 1);

        // Backpressure: 10 idle cycles in FETCH, then a single last vector.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("bp_ready", 32'(vec_ready), 1);
        check_eq("bp_start_clears_illegal", 32'(illegal), 0);
        ctrl_before = ctrl_cnt;
        bp_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (dif.dut_ctrl || !busy || !vec_ready) bp_ok = 1'b0;
            @(negedge clk);
        end
        check_eq("bp_stall_hold", 32'(bp_ok), 1);
        check_eq("bp_no_ctrl", ctrl_cnt - ctrl_before, 0);
        vec_valid = 1'b1; vec_sw = 2'd2; vec_last = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0; vec_last = 1'b0;
        w = 0;
        while (!done && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("bp_done_seen", 32'(done), 1);
        check_eq("bp_one_step", ctrl_cnt - ctrl_before, 1);
        check_eq("bp_step_cnt", 32'(step_cnt), 1);
        check_eq("bp_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);

        // Reset during the second vector's STEP.
        done_before = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vec_valid = 1'b1; vec_sw = 2'd0; vec_last = 1'b0;
        w = 0;
        while (!vec_ready && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        vec_sw = 2'd1;
        w = 0;
        while (!vec_ready && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        @(negedge clk);
        check_eq("midrun_in_step", 32'(dif.dut_ctrl), 1);
        check_eq("midrun_step_before", 32'(step_cnt), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec_valid = 1'b0;
        check_eq("midrun_busy_ctrl", 32'({busy, dif.dut_ctrl}), 0);
        check_eq("midrun_counters", 32'({err_cnt, step_cnt}), 0);
        repeat (5) @(negedge clk);
        check_eq("midrun_no_done", done_cnt - done_before, 0);

        // cfg_we and start while busy; sequence 1,1,1,1 exercises entry {1,1}.
        run_vectors(4, 8'b01_01_01_01, 1'b0, 1'b1, lat);
        check_eq("busy_latency", lat, 17);
        check_eq("busy_err_cnt", 32'(err_cnt), 0);
        check_eq("busy_step_cnt", 32'(step_cnt), 4);
        run_vectors(2, 8'b00_00_01_01, 1'b0, 1'b0, lat);
        check_eq("busy_table_kept", 32'(err_cnt), 0);

        // Error on step 0 of a 4-vector run.
        fault_step = 0; fault_val = 3'd1;
        run_vectors(4, 8'b11_10_01_00, 1'b0, 1'b0, lat);
        fault_step = -1;
        check_eq("stop_first_err", 32'(first_err_step), 0);
`ifdef MOORE_CHK_STOP_ON_ERR_EN
        check_eq("stop_err_cnt", 32'(err_cnt), 1);
        check_eq("stop_step_cnt", 32'(step_cnt), 1);
        check_eq("stop_latency", lat, 5);
`else
        check_eq("stop_err_cnt", 32'(err_cnt), 2);
        check_eq("stop_step_cnt", 32'(step_cnt), 4);
        check_eq("stop_latency", lat, 17);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
